// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg -- shared definitions for the SPI arbiter slice.
//   SPI_ARB_DATA_WIDTH : default SPI word width (12)
//   SPI_ARB_MAX_REQ    : largest supported requester count (8)
//   req_idx_t          : requester index / round-robin pointer type
//   spi_arb_state_e    : arbiter FSM state encoding
//   onehot_to_idx()    : one-hot vector to index
package spi_arb_pkg;

    localparam int SPI_ARB_DATA_WIDTH = 12;
    localparam int SPI_ARB_MAX_REQ    = 8;

    typedef logic [2:0] req_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } spi_arb_state_e;

    function automatic req_idx_t onehot_to_idx(input logic [SPI_ARB_MAX_REQ-1:0] oh);
        req_idx_t idx;
        idx = '0;
        for (int i = 0; i < SPI_ARB_MAX_REQ; i++) begin
            if (oh[i]) idx = req_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if -- link between the arbiter and the shared SPI master.
//   spi_ssel_n  : slave select, active-low, driven by the arbiter
//   spi_start   : one-cycle transfer start pulse, driven by the arbiter
//   spi_tx_data : word to shift out, driven by the arbiter
//   spi_done    : one-cycle end-of-transfer pulse, driven by the SPI master
//   spi_rx_data : received word, driven by the SPI master
// Handshake: pulse-based, no backpressure. spi_start is high for exactly one
// cycle while spi_ssel_n is low; spi_tx_data is stable from that cycle until
// spi_done. spi_done is a single-cycle pulse qualifying spi_rx_data and is only
// honoured while the arbiter is waiting for it; at any other time it is ignored.
// Modports: master = arbiter side, slave = SPI master engine side.
interface spi_arbiter_if import spi_arb_pkg::*; #(
    parameter int DATA_WIDTH = SPI_ARB_DATA_WIDTH
);
    logic                  spi_ssel_n;
    logic                  spi_start;
    logic [DATA_WIDTH-1:0] spi_tx_data;
    logic                  spi_done;
    logic [DATA_WIDTH-1:0] spi_rx_data;

    modport master (
        output spi_ssel_n, spi_start, spi_tx_data,
        input  spi_done, spi_rx_data
    );

    modport slave (
        input  spi_ssel_n, spi_start, spi_tx_data,
        output spi_done, spi_rx_data
    );
endinterface

// File: rtl/spi_arbiter_rr_arbiter.sv
// rr_arbiter -- combinational round-robin selector.
//   req     : request vector
//   pointer : index with highest priority this round
//   winner  : one-hot grant, first set request at or after pointer (wrapping)
module rr_arbiter import spi_arb_pkg::*; #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           pointer,
    output logic [NUM_REQ-1:0] winner
);
    logic found;
    int   idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(pointer) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter -- shares one SPI master among NUM_REQ requesters.
//   clk, rst    : clock; synchronous active-low reset
//   req         : per-requester level request, held until ack
//   req_wdata   : flattened TX words, slice i for requester i
//   grant       : one-hot current owner, zero when idle
//   ack         : one-hot, one-cycle completion pulse
//   rdata       : received word, meaningful while ack is nonzero
//   err         : one-cycle timeout flag, coincident with ack
//   dbg_state   : current FSM state
//   spi         : arbiter side of spi_arbiter_if
// Optional feature macro SPI_ARB_TIMEOUT_EN: enables a WAIT watchdog that ends
// the transfer after TIMEOUT_CYCLES cycles with err=1 and rdata=0. Without it
// WAIT lasts until spi_done and err is constant 0.
// All outputs are registered; spi_start is raised on the edge leaving START,
// which puts it SETUP_CYCLES+2 cycles after req rises in IDLE.
module spi_arbiter import spi_arb_pkg::*; #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = SPI_ARB_DATA_WIDTH,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          err,
    output spi_arb_state_e                dbg_state,
    spi_arbiter_if.master                 spi
);
    localparam int SC_W       = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int SETUP_LAST = (SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0;

    if (NUM_REQ < 2 || NUM_REQ > SPI_ARB_MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("spi_arbiter: parameter out of range");
    end

    spi_arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d, ack_q, ack_d, win;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d, tx_q, tx_d;
    logic                    start_q, start_d, ssel_q, ssel_d;
    req_idx_t                ptr_q, ptr_d, win_idx, grant_idx, ptr_next;
    logic [SC_W-1:0]         setup_q, setup_d;
    logic                    timed_out;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req),
        .pointer (ptr_q),
        .winner  (win)
    );

    assign win_idx   = onehot_to_idx(SPI_ARB_MAX_REQ'(win));
    assign grant_idx = onehot_to_idx(SPI_ARB_MAX_REQ'(grant_q));
    assign ptr_next  = (int'(grant_idx) == NUM_REQ - 1) ? req_idx_t'(0) : grant_idx + req_idx_t'(1);

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] to_q, to_d;
    logic            err_q, err_d;

    // Fires on the last allowed WAIT cycle; a real spi_done in that cycle wins.
    assign timed_out = (to_q == TO_W'(TIMEOUT_CYCLES - 1)) && !spi.spi_done;
    assign err       = err_q;
`else
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        tx_d    = tx_q;
        start_d = 1'b0;
        ssel_d  = ssel_q;
        ptr_d   = ptr_q;
        setup_d = setup_q;
`ifdef SPI_ARB_TIMEOUT_EN
        to_d    = to_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d = win;
                    ssel_d  = 1'b0;
                    tx_d    = req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    setup_d = '0;
                    state_d = (SETUP_CYCLES == 0) ? ST_START : ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (setup_q == SC_W'(SETUP_LAST)) state_d = ST_START;
                else                                setup_d = setup_q + SC_W'(1);
            end
            ST_START: begin
                start_d = 1'b1;
                state_d = ST_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                to_d    = '0;
`endif
            end
            ST_WAIT: begin
                if (spi.spi_done || timed_out) begin
                    state_d = ST_RESP;
                    ack_d   = grant_q;
                    grant_d = '0;
                    ssel_d  = 1'b1;
                    rdata_d = timed_out ? '0 : spi.spi_rx_data;
                    ptr_d   = ptr_next;
`ifdef SPI_ARB_TIMEOUT_EN
                    err_d   = timed_out;
                end else begin
                    to_d    = to_q + TO_W'(1);
`endif
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            tx_q    <= '0;
            start_q <= 1'b0;
            ssel_q  <= 1'b1;
            ptr_q   <= '0;
            setup_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            to_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            tx_q    <= tx_d;
            start_q <= start_d;
            ssel_q  <= ssel_d;
            ptr_q   <= ptr_d;
            setup_q <= setup_d;
`ifdef SPI_ARB_TIMEOUT_EN
            to_q    <= to_d;
            err_q   <= err_d;
`endif
        end
    end

    assign grant           = grant_q;
    assign ack             = ack_q;
    assign rdata           = rdata_q;
    assign dbg_state       = state_q;
    assign spi.spi_ssel_n  = ssel_q;
    assign spi.spi_start   = start_q;
    assign spi.spi_tx_data = tx_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter -- self-checking bench for spi_arbiter (NUM_REQ=4, 12-bit words).
// A vector table drives simultaneous request patterns with a reactive SPI
// master model; hand-written sequences cover latency, spurious spi_done,
// dropped req, mid-transfer reset and the WAIT watchdog (SPI_ARB_TIMEOUT_EN).
module tb_spi_arbiter;
    import spi_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 12;
    localparam int SC = 2;
    localparam int TO = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR-1:0]        req;
    logic [NR*DW-1:0]     req_wdata;
    logic [NR-1:0]        grant, ack;
    logic [DW-1:0]        rdata;
    logic                 err;
    spi_arb_state_e       dbg_state;

    spi_arbiter_if #(.DATA_WIDTH(DW)) spi_if();

    spi_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .SETUP_CYCLES(SC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_wdata (req_wdata),
        .grant     (grant),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .dbg_state (dbg_state),
        .spi       (spi_if)
    );

    // clock
    always #5 clk = ~clk;

    // bookkeeping
    int n_cmp  = 0;
    int n_fail = 0;
    int ack_count = 0;

    logic [NR+DW:0]   exp_q[$];        // {ack, err, rdata}
    logic [NR+DW-1:0] exp_start_q[$];  // {grant, spi_tx_data}
    logic [NR+DW:0]   mon_e;
    logic [NR+DW-1:0] mon_s;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] xform(input logic [DW-1:0] w);
        return ~w ^ 12'h5A5;
    endfunction

    // reactive SPI master model
    bit            auto_slave = 1'b0;
    bit            pend = 1'b0;
    int            dly = 0;
    logic [DW-1:0] pend_rx;

    always @(negedge clk) begin
        if (auto_slave) begin
            spi_if.spi_done = 1'b0;
            if (pend) begin
                if (dly == 0) begin
                    spi_if.spi_done    = 1'b1;
                    spi_if.spi_rx_data = pend_rx;
                    pend = 1'b0;
                end else begin
                    dly--;
                end
            end
            if (spi_if.spi_start) begin
                pend    = 1'b1;
                dly     = $urandom_range(0, 3);
                pend_rx = xform(spi_if.spi_tx_data);
            end
        end
    end

    // scoreboard / monitor; requesters drop req on their ack
    bit gap_ok = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            if (ack != '0) begin
                ack_count++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got ack=%b, expected none", ack);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack_resp", {ack, err, rdata}, mon_e);
                end
                req    = req & ~ack;
                gap_ok = 1'b0;
            end else if (spi_if.spi_ssel_n) begin
                gap_ok = 1'b1;
            end
            if (spi_if.spi_start) begin
                check("ssel_gap", gap_ok, 1);
                check("ssel_low_at_start", spi_if.spi_ssel_n, 0);
                if (exp_start_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_start: got grant=%b, expected no start", grant);
                end else begin
                    mon_s = exp_start_q.pop_front();
                    check("start_grant_tx", {grant, spi_if.spi_tx_data}, mon_s);
                end
            end
        end
    end

    // driver tasks
    task automatic pulse_done(input logic [DW-1:0] rx);
        spi_if.spi_rx_data = rx;
        spi_if.spi_done    = 1'b1;
        @(negedge clk);
        spi_if.spi_done    = 1'b0;
    endtask

    task automatic wait_start(output int cyc, input int budget);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!spi_if.spi_start && cyc < budget);
        if (!spi_if.spi_start) begin
            n_cmp++;
            n_fail++;
            $display("FAIL start_timeout: got no spi_start in %0d cycles, expected one", budget);
        end
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || exp_start_q.size() != 0 || req != '0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d acks pending, expected 0", exp_q.size());
            exp_q.delete();
            exp_start_q.delete();
            req = '0;
        end
    endtask

    task automatic expect_txn(input int idx, input logic [DW-1:0] w,
                              input logic [DW-1:0] rx, input logic e);
        logic [NR-1:0] oh;
        oh = NR'(1) << idx;
        exp_start_q.push_back({oh, w});
        exp_q.push_back({oh, e, rx});
    endtask

    // vector table
    typedef struct packed {
        logic [NR-1:0]      mask;
        logic [2:0]         n;
        logic [3:0][1:0]    ord;   // ord[0] served first
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "global timeout");
    end

    initial begin
        int            idx, lat, c0, t;
        logic [DW-1:0] w;

        rst = 1'b0;
        req = '0;
        req_wdata = '0;
        spi_if.spi_done = 1'b0;
        spi_if.spi_rx_data = '0;

        // round-robin orders derived by hand, pointer carried from reset
        vecs[0] = '{mask: 4'b1111, n: 3'd4, ord: {2'd3, 2'd2, 2'd1, 2'd0}};
        vecs[1] = '{mask: 4'b0001, n: 3'd1, ord: {2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[2] = '{mask: 4'b0100, n: 3'd1, ord: {2'd0, 2'd0, 2'd0, 2'd2}};
        vecs[3] = '{mask: 4'b1001, n: 3'd2, ord: {2'd0, 2'd0, 2'd0, 2'd3}};
        vecs[4] = '{mask: 4'b0110, n: 3'd2, ord: {2'd0, 2'd0, 2'd2, 2'd1}};
        vecs[5] = '{mask: 4'b0011, n: 3'd2, ord: {2'd0, 2'd0, 2'd1, 2'd0}};
        vecs[6] = '{mask: 4'b1010, n: 3'd2, ord: {2'd0, 2'd0, 2'd1, 2'd3}};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_ack", ack, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", err, 0);
        check("rst_ssel_n", spi_if.spi_ssel_n, 1);
        check("rst_start", spi_if.spi_start, 0);
        check("rst_tx", spi_if.spi_tx_data, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b1;
        @(negedge clk);

        // table-driven round-robin patterns
        auto_slave = 1'b1;
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < NR; i++) req_wdata[i*DW +: DW] = DW'($urandom_range(0, 4095));
            for (int k = 0; k < int'(vecs[v].n); k++) begin
                idx = int'(vecs[v].ord[k]);
                w   = req_wdata[idx*DW +: DW];
                expect_txn(idx, w, xform(w), 1'b0);
            end
            req = vecs[v].mask;
            wait_drain(400);
            @(negedge clk);
        end
        auto_slave = 1'b0;
        repeat (2) @(negedge clk);

        // single request: latency, tx word and returned word (pointer is 2)
        req_wdata[0 +: DW] = 12'hA5C;
        expect_txn(0, 12'hA5C, 12'h3C1, 1'b0);
        req = 4'b0001;
        wait_start(lat, 20);
        check("start_latency", lat, SC + 2);
        repeat (2) @(negedge clk);
        pulse_done(12'h3C1);
        wait_drain(50);
        @(negedge clk);

        // spurious spi_done in IDLE is ignored
        c0 = ack_count;
        pulse_done(12'hFFF);
        check("spurious_state", dbg_state, ST_IDLE);
        check("spurious_ssel", spi_if.spi_ssel_n, 1);
        check("spurious_grant", grant, 0);
        check("spurious_ack_cnt", ack_count, c0);

        // req dropped during WAIT still completes (pointer is 1)
        req_wdata[1*DW +: DW] = 12'h0F0;
        expect_txn(1, 12'h0F0, 12'h123, 1'b0);
        req = 4'b0010;
        wait_start(lat, 20);
        @(negedge clk);
        req = '0;
        check("drop_state", dbg_state, ST_WAIT);
        repeat (3) @(negedge clk);
        pulse_done(12'h123);
        wait_drain(50);
        @(negedge clk);

        // reset during WAIT aborts without ack (pointer is 2)
        req_wdata[2*DW +: DW] = 12'h777;
        exp_start_q.push_back({4'b0100, 12'h777});
        req = 4'b0100;
        wait_start(lat, 20);
        @(negedge clk);
        c0  = ack_count;
        rst = 1'b0;
        @(negedge clk);
        check("abort_grant", grant, 0);
        check("abort_ack", ack, 0);
        check("abort_ssel", spi_if.spi_ssel_n, 1);
        check("abort_start", spi_if.spi_start, 0);
        check("abort_tx", spi_if.spi_tx_data, 0);
        check("abort_rdata", rdata, 0);
        check("abort_err", err, 0);
        check("abort_state", dbg_state, ST_IDLE);
        req = '0;
        rst = 1'b1;
        pulse_done(12'hABC);
        repeat (4) @(negedge clk);
        check("abort_ack_cnt", ack_count, c0);
        check("abort_idle", dbg_state, ST_IDLE);

        // WAIT without spi_done (pointer reset to 0)
        req_wdata[0 +: DW] = 12'h321;
        exp_start_q.push_back({4'b0001, 12'h321});
        req = 4'b0001;
        wait_start(lat, 20);
`ifdef SPI_ARB_TIMEOUT_EN
        exp_q.push_back({4'b0001, 1'b1, 12'h000});
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (ack == '0 && t < 100);
        check("timeout_cycles", t, TO);
        wait_drain(20);
        @(negedge clk);
        auto_slave = 1'b1;
        req_wdata[3*DW +: DW] = 12'h9E1;
        expect_txn(3, 12'h9E1, xform(12'h9E1), 1'b0);
        req = 4'b1000;
        wait_drain(100);
        auto_slave = 1'b0;
`else
        t = 0;
        c0 = ack_count;
        repeat (40) begin
            @(negedge clk);
            t++;
        end
        check("nowd_state", dbg_state, ST_WAIT);
        check("nowd_ack_cnt", ack_count, c0);
        exp_q.push_back({4'b0001, 1'b0, 12'h456});
        pulse_done(12'h456);
        wait_drain(20);
`endif
        repeat (3) @(negedge clk);
        check("final_queue", exp_q.size() + exp_start_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one SPI master (legal range 2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 12, SPI word width.
REQ-003 SHALL have parameter SETUP_CYCLES, default 2, number of cycles spi_ssel_n is low before spi_start.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, WAIT-state watchdog limit.
REQ-005 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port req  input  NUM_REQ  per-requester level request, held until ack.
REQ-008 SHALL have port req_wdata  input  NUM_REQ*DATA_WIDTH  flattened TX words; slice i belongs to requester i.
REQ-009 SHALL have port grant  output  NUM_REQ  one-hot current owner, all-zero when idle.
REQ-010 SHALL have port ack  output  NUM_REQ  one-hot, one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  DATA_WIDTH  RX word, valid only while ack is nonzero.
REQ-012 SHALL have port err  output  1  one-cycle timeout flag, coincident with ack.
REQ-013 SHALL have port spi_ssel_n  output  1  slave select to the master's ssel_in, active-low.
REQ-014 SHALL have port spi_start  output  1  one-cycle transfer start pulse to the master.
REQ-015 SHALL have port spi_tx_data  output  DATA_WIDTH  word to shift out, stable from spi_start until spi_done.
REQ-016 SHALL have port spi_done  input  1  one-cycle pulse from the master marking the end of a transfer.
REQ-017 SHALL have port spi_rx_data  input  DATA_WIDTH  master receive register (d_reg_master), valid with spi_done.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, START, WAIT, RESP.
REQ-019 IDLE: on any req bit set, SHALL select the winner round-robin from the priority pointer, register grant, drive spi_ssel_n low, latch spi_tx_data from that requester's slice, and go to SETUP on the next edge.
REQ-020 SETUP: SHALL hold for SETUP_CYCLES cycles, then go to START; with SETUP_CYCLES=0 it goes straight to START.
REQ-021 START: SHALL assert spi_start for exactly one cycle, then go to WAIT.
REQ-022 WAIT: on spi_done, SHALL latch spi_rx_data into rdata and go to RESP.
REQ-023 RESP: SHALL pulse ack[winner] for one cycle, raise spi_ssel_n, clear grant, set pointer to winner+1 (wrapping NUM_REQ-1 to 0), and return to IDLE.
REQ-024 spi_ssel_n SHALL be high for at least one cycle (IDLE) between consecutive transactions, including back-to-back requests.
REQ-025 Simultaneous requests SHALL be served in round-robin order starting at the pointer; after reset the pointer is 0.
REQ-026 If a requester drops req while granted, the transaction SHALL still complete and ack SHALL still pulse.
REQ-027 spi_done arriving outside WAIT SHALL be ignored.
REQ-028 Latency from req rising in IDLE to spi_start SHALL be SETUP_CYCLES+2 cycles.

Reset
REQ-029 While rst=0 at a clock edge, the block SHALL enter IDLE with grant=0, ack=0, rdata=0, err=0, spi_start=0, spi_tx_data=0, spi_ssel_n=1, pointer=0, and all counters cleared.
REQ-030 A reset mid-transaction SHALL abort with no ack pulse; spi_ssel_n SHALL be high after that edge.

Configuration
REQ-031 With SPI_ARB_TIMEOUT_EN defined, a WAIT counter SHALL run; after TIMEOUT_CYCLES cycles in WAIT without spi_done, the block SHALL go to RESP with err=1 and rdata=0.
REQ-032 Without SPI_ARB_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL wait indefinitely, and err SHALL be tied to 0.

Structure
REQ-033 Shared package spi_arb_pkg SHALL hold the FSM state encoding and the DATA_WIDTH default constant (12).
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req and pointer, output one-hot winner), purely combinational.

Verification
REQ-035 Single request: req=4'b0001, wdata0=12'hA5C, master returns 12'h3C1 -> spi_start 4 cycles after req, spi_tx_data=12'hA5C, then ack=4'b0001 and rdata=12'h3C1.
REQ-036 All four requesting from reset -> grants in order 0,1,2,3; each transaction is separated by at least one cycle of spi_ssel_n high.
REQ-037 Pointer=3 with req=4'b1001 -> requester 3 is served, then requester 0 (wrap-around).
REQ-038 With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no spi_done -> ack and err=1 and rdata=0 after 16 cycles in WAIT; the next request proceeds normally.
REQ-039 rst=0 asserted during WAIT -> no ack, spi_ssel_n=1 after that edge, all outputs at reset values; a later spi_done is ignored.
REQ-040 Spurious spi_done in IDLE, and req dropped during WAIT -> no state change in IDLE; ack still pulses for the dropped requester.
